// File: rtl/riscv_if.sv
// -----------------------------------------------------------------------------
// riscv_if : RV32I instruction fetch stage
//
// Issues word-aligned fetch requests to instruction memory, collects the
// in-order responses into a small {pc, inst} FIFO and presents the FIFO head
// to decode. A redirect from execute flushes the FIFO, turns every request
// still in flight into a "discard" credit and restarts fetching at the target.
// When nothing is buffered the stage presents a NOP with valid_o low.
//
// Handshakes:
//   imem request : a request transfers on a cycle with imem_req_o & imem_gnt_i;
//                  an ungranted request may be withdrawn (redirect) and its
//                  address is otherwise held until granted.
//   imem response: imem_rvalid_i marks one response per earlier grant, in
//                  grant order; there is no back-pressure on responses.
//   decode       : an instruction transfers on a cycle with valid_o & ~stall_i
//                  & ~redirect_i; stall_i is the inverse of a ready signal.
//
// Parameters:
//   RESET_PC      first fetch address after reset
//   FIFO_DEPTH    response buffer entries (power of 2, >= 2)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req_o            fetch request valid
//   imem_addr_o           fetch address (word aligned)
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i         response valid
//   imem_rdata_i          response instruction word
//   redirect_i            taken branch / jump from execute
//   redirect_pc_i         redirect target (bits [1:0] ignored)
//   stall_i               decode cannot accept this cycle
//   pc_o, inst_o, valid_o presented instruction
// -----------------------------------------------------------------------------
module riscv_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    // Fetch address and request bookkeeping
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;   // granted, response not yet seen
    logic [CW-1:0] r_discard;       // responses still owed to a flushed stream

    // Request PC tags, written at grant, read when the response returns
    logic [31:0]   r_tag_pc [FIFO_DEPTH];
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;

    // Response FIFO
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_last_pc;       // PC shown while the FIFO is empty

    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_grant;
    logic [CW:0]   w_committed;
    logic [31:0]   w_redirect_pc;
    logic          w_unused_low_bits;

    assign w_redirect_pc     = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_low_bits = ^redirect_pc_i[1:0];

    // -------------------------------------------------------------------------
    // Output side
    // -------------------------------------------------------------------------
    assign valid_o = (r_count != '0);
    assign pc_o    = valid_o ? r_fifo_pc[r_rd_ptr]   : r_last_pc;
    assign inst_o  = valid_o ? r_fifo_inst[r_rd_ptr] : NOP;

    assign w_pop   = valid_o & ~stall_i & ~redirect_i;

    // A response can only be accepted into the FIFO if it belongs to the
    // current stream: not owed to an older stream and not racing a redirect.
    assign w_push  = imem_rvalid_i & (r_discard == '0) & ~redirect_i;

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    // Every request in flight already owns a FIFO slot, so a new request is
    // only issued while in-flight plus buffered entries (after this cycle's
    // pop) leave room. This is what makes FIFO overflow impossible.
    assign w_committed = {1'b0, r_outstanding} + {1'b0, r_count} - (CW+1)'(w_pop);

    // rst_n gates the request so that nothing is asked for while in reset but
    // the first request goes out in the first cycle after release.
    assign w_req       = rst_n & ~redirect_i & (w_committed < DEPTH_V);
    assign w_grant     = w_req & imem_gnt_i;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;

    // -------------------------------------------------------------------------
    // Fetch PC, outstanding and discard counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                // Everything still in flight after this cycle is stale; a
                // response arriving right now is dropped by w_push instead.
                r_discard  <= r_outstanding - CW'(imem_rvalid_i);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rvalid_i && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag FIFO: one entry per outstanding request. It is not flushed on a
    // redirect because stale responses still arrive and must retire their tag.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_tag_pc[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_tag_pc[r_tag_wr] <= r_fetch_pc;
                r_tag_wr           <= r_tag_wr + PW'(1);
            end
            if (imem_rvalid_i) begin
                r_tag_rd <= r_tag_rd + PW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_inst[i] <= '0;
            end
        end else if (redirect_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_tag_pc[r_tag_rd];
                r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Last consumed PC, shown on pc_o whenever the FIFO runs dry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pc <= RESET_PC;
        end else if (w_pop) begin
            r_last_pc <= r_fifo_pc[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_riscv_if.sv
module tb_riscv_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    riscv_if #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- counters and check helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory content: a function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // ---------------- memory model + reference model ----------------
    // Each granted request is remembered with the address the DUT asked for,
    // the PC the fetch stream should have asked for, the redirect epoch it
    // belongs to and the cycle its response may be returned.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          ready;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];      // PCs the decode side should see, in order
    logic [31:0] m_req_pc;      // next address the fetch stream should request
    logic [31:0] m_last_pc;     // PC shown when nothing is buffered
    int          m_epoch = 0;
    int          cyc = 0;
    int          n_pops = 0;
    int          gnt_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;

    mreq_t       h;
    mreq_t       nq;
    logic        e_valid;
    logic        e_pop;
    logic        e_req;

    always begin
        @(negedge clk);
        cyc++;
        #2;
        // memory drives its outputs for the coming rising edge
        if (!rst_n) begin
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end else begin
            imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
            if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_q[0].addr);
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = $urandom;
            end
        end
        #2;
        // compare against the model, then advance it across the rising edge
        if (!rst_n) begin
            check1("rst_req", imem_req_o, 1'b0);
            check32("rst_addr", imem_addr_o, RESET_PC);
            check1("rst_valid", valid_o, 1'b0);
            check32("rst_pc", pc_o, RESET_PC);
            check32("rst_inst", inst_o, NOP);
            mem_q.delete();
            exp_q.delete();
            m_req_pc  = RESET_PC;
            m_last_pc = RESET_PC;
            m_epoch++;
        end else begin
            e_valid = (exp_q.size() != 0);
            e_pop   = e_valid && !stall_i && !redirect_i;
            e_req   = !redirect_i && ((mem_q.size() + exp_q.size() - int'(e_pop)) < DEPTH);
            check1("req", imem_req_o, e_req);
            if (imem_req_o) check32("addr", imem_addr_o, m_req_pc);
            check1("valid", valid_o, e_valid);
            if (e_valid) begin
                check32("pc", pc_o, exp_q[0]);
                check32("inst", inst_o, mem_word(exp_q[0]));
            end else begin
                check32("idle_pc", pc_o, m_last_pc);
                check32("idle_inst", inst_o, NOP);
            end
            if (e_pop) begin
                m_last_pc = exp_q.pop_front();
                n_pops++;
            end
            if (imem_rvalid_i && mem_q.size() > 0) begin
                h = mem_q.pop_front();
                if (!redirect_i && h.epoch == m_epoch) exp_q.push_back(h.pc);
            end
            if (redirect_i) begin
                exp_q.delete();
                m_req_pc = {redirect_pc_i[31:2], 2'b00};
                m_epoch++;
            end
            if (imem_req_o && imem_gnt_i) begin
                nq.addr  = imem_addr_o;
                nq.pc    = m_req_pc;
                nq.epoch = m_epoch;
                nq.ready = cyc + 1 + $urandom_range(lat_min, lat_max);
                mem_q.push_back(nq);
                m_req_pc = m_req_pc + 32'd4;
            end
        end
    end

    // ---------------- driver helpers ----------------
    // Wait (bounded) for valid_o, sampled mid-cycle.
    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #6;
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check1(name, seen, 1'b1);
    endtask

    // Redirect table: target, first and second request addresses
    typedef struct {
        logic [31:0] target;
        logic [31:0] first;
        logic [31:0] second;
    } redir_vec_t;

    redir_vec_t vecs[5];

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] pc_hold;
        logic [31:0] inst_hold;
        int          p0;
        bit          found;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFB, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        vecs[3] = '{32'h0000_1002, 32'h0000_1000, 32'h0000_1004};
        vecs[4] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

        repeat (3) @(negedge clk);

        // --- reset release, 1-cycle memory ---
        rst_n = 1'b1;
        #6;
        check1("first_req", imem_req_o, 1'b1);
        check32("first_addr", imem_addr_o, RESET_PC);
        check1("lat_c0_valid", valid_o, 1'b0);
        @(negedge clk); #6;
        check1("lat_c1_valid", valid_o, 1'b0);
        check32("second_addr", imem_addr_o, RESET_PC + 32'd4);
        @(negedge clk); #6;
        check1("lat_c2_valid", valid_o, 1'b1);
        check32("lat_c2_pc", pc_o, RESET_PC);
        check32("lat_c2_inst", inst_o, mem_word(RESET_PC));
        @(negedge clk); #6;
        check32("lat_c3_pc", pc_o, RESET_PC + 32'd4);
        check32("lat_c3_inst", inst_o, mem_word(RESET_PC + 32'd4));

        // --- sustained throughput ---
        p0 = n_pops;
        repeat (20) @(negedge clk);
        #6;
        check32("throughput", 32'(n_pops - p0), 32'd20);

        // --- stall for 5 cycles ---
        @(negedge clk);
        stall_i = 1'b1;
        #6;
        pc_hold   = pc_o;
        inst_hold = inst_o;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #6;
            check32("stall_pc", pc_o, pc_hold);
            check32("stall_inst", inst_o, inst_hold);
            check1("stall_credit", (mem_q.size() + exp_q.size()) <= DEPTH, 1'b1);
        end
        @(negedge clk);
        stall_i = 1'b0;
        #6;
        check32("stall_release_pc", pc_o, pc_hold);
        repeat (5) @(negedge clk);

        // --- redirect with two responses in flight (2-cycle memory) ---
        lat_min = 1;
        lat_max = 1;
        found   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #6;
            if (mem_q.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        check1("two_in_flight", found, 1'b1);
        @(negedge clk);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        @(negedge clk);
        redirect_i = 1'b0;
        #6;
        check1("redir_req", imem_req_o, 1'b1);
        check32("redir_addr", imem_addr_o, 32'h0000_0100);
        wait_valid("redir_valid_timeout");
        check32("redir_first_pc", pc_o, 32'h0000_0100);
        check32("redir_first_inst", inst_o, mem_word(32'h0000_0100));

        // --- redirect coinciding with a response, then a second redirect ---
        lat_min = 0;
        lat_max = 1;
        found   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (imem_rvalid_i) begin
                found = 1'b1;
                break;
            end
        end
        check1("rvalid_seen", found, 1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(negedge clk);
        redirect_pc_i = 32'h0000_0300;
        @(negedge clk);
        redirect_i = 1'b0;
        wait_valid("double_redir_timeout");
        check32("double_redir_pc", pc_o, 32'h0000_0300);
        check32("double_redir_inst", inst_o, mem_word(32'h0000_0300));

        // --- table of redirect targets with 1-cycle memory ---
        lat_min = 0;
        lat_max = 0;
        repeat (5) @(negedge clk);
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            redirect_i    = 1'b1;
            redirect_pc_i = vecs[v].target;
            @(negedge clk);
            redirect_i = 1'b0;
            #6;
            check1("tbl_req", imem_req_o, 1'b1);
            check32("tbl_first_addr", imem_addr_o, vecs[v].first);
            check1("tbl_r1_valid", valid_o, 1'b0);
            @(negedge clk); #6;
            check32("tbl_second_addr", imem_addr_o, vecs[v].second);
            check1("tbl_r2_valid", valid_o, 1'b0);
            @(negedge clk); #6;
            check1("tbl_r3_valid", valid_o, 1'b1);
            check32("tbl_r3_pc", pc_o, vecs[v].first);
            check32("tbl_r3_inst", inst_o, mem_word(vecs[v].first));
            repeat (3) @(negedge clk);
        end

        // --- randomized traffic ---
        gnt_pct = 70;
        lat_min = 0;
        lat_max = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            stall_i    = ($urandom_range(0, 99) < 25);
            redirect_i = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0)
                redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc_i = $urandom;
        end
        @(negedge clk);
        stall_i    = 1'b0;
        redirect_i = 1'b0;

        // --- reset with requests outstanding ---
        gnt_pct = 100;
        found   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #6;
            if (mem_q.size() > 0 && exp_q.size() > 0) begin
                found = 1'b1;
                break;
            end
        end
        check1("busy_before_reset", found, 1'b1);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check1("async_rst_req", imem_req_o, 1'b0);
        check1("async_rst_valid", valid_o, 1'b0);
        check32("async_rst_inst", inst_o, NOP);
        check32("async_rst_pc", pc_o, RESET_PC);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #6;
        check1("restart_req", imem_req_o, 1'b1);
        check32("restart_addr", imem_addr_o, RESET_PC);
        wait_valid("restart_valid_timeout");
        check32("restart_pc", pc_o, RESET_PC);
        check32("restart_inst", inst_o, mem_word(RESET_PC));
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
